wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter and register scoreboard for the MIPS core's single-write-port register file. Three producers (ALU, load unit, multiply/divide unit) compete for the one `write_back_en`/`write_back_reg`/`write_back` port; this block grants one per cycle, registers the winning write and drives the register file directly. It also keeps a 32-bit busy scoreboard, set at issue and cleared on write-back, which decode uses to stall on RAW hazards.

## Interface
- `DATA_W`, default 32: write-back data width.
- `REG_W`, default 5: register index width (32 registers).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; cannot be back-pressured.
- `alu_reg`  in  REG_W  ALU destination.
- `alu_data`  in  DATA_W  ALU result.
- `mem_valid` / `mem_ready`  in / out  1  load-unit handshake.
- `mem_reg`, `mem_data`  in  REG_W, DATA_W  load destination and data.
- `mdu_valid` / `mdu_ready`  in / out  1  mul/div handshake.
- `mdu_reg`, `mdu_data`  in  REG_W, DATA_W  mul/div destination and data.
- `issue_en`  in  1  decode issues an instruction that writes `issue_reg`.
- `issue_reg`  in  REG_W  destination being issued.
- `write_back_en`  out  1  register-file write enable (registered).
- `write_back_reg`  out  REG_W  register-file write index (registered).
- `write_back`  out  DATA_W  register-file write data (registered).
- `busy`  out  32  scoreboard; bit n = write to register n pending.

## Operation
- Priority: ALU absolute; when `alu_valid`=0, round-robin between MEM and MDU.
- `mem_ready` = !alu_valid && (!mdu_valid || rr_ptr==MEM); `mdu_ready` = !alu_valid && (!mem_valid || rr_ptr==MDU). Both combinational from valids and `rr_ptr`.
- Transfer = valid && ready. At most one transfer per cycle.
- `rr_ptr` (1 bit, MEM=0, MDU=1) toggles to the other source only after a MEM or MDU transfer; unchanged on ALU transfers or idle cycles.
- Winning (reg, data) captured into the output register; `write_back_en` = 1 for exactly that cycle, 0 otherwise.
- Writes to register 0: accepted (handshake completes), but `write_back_en` stays 0; `write_back_reg`/`write_back` hold previous values.
- When `write_back_en`=0, `write_back_reg`/`write_back` hold last values.
- Scoreboard: `issue_en` with `issue_reg`≠0 sets the bit; an output-stage write (`write_back_en`=1) clears bit `write_back_reg`.
- Same register set and cleared in one cycle: set wins (newer instruction outstanding).
- `busy[0]` constantly 0.
- A producer writing a register whose busy bit is clear is not an error; the write is performed, and no bit changes.

## Timing
- Reset (async, immediate): `write_back_en`=0, `write_back_reg`=0, `write_back`=0, `busy`=0, `rr_ptr`=MEM. Ready outputs follow the combinational equations immediately.
- Latency: transfer in cycle N -> `write_back_en`=1 in cycle N+1; register file commits at end of N+1.
- Busy clears at the same edge the register file commits; a combinational read in N+2 sees the new value and a clear busy bit.
- Set from `issue_en` is visible the cycle after the issue edge.
- Reset mid-operation: pending output write is dropped (not committed); all busy bits clear; producers must re-present after reset.
- Sustained throughput: one write per cycle; ALU streaming starves MEM/MDU by design.

## Structure
- Shared package `cpu_pkg`: `DATA_W`, `REG_W`, `NUM_REGS`=32, source encoding `SRC_MEM`=0/`SRC_MDU`=1.
- One natural sub-module: `wb_scoreboard` (busy vector, set/clear with set priority, bit 0 forced 0); arbitration and output register stay in `wb_arbiter`.

## Test plan
- Reset: assert `rst` mid-cycle with writes pending -> all outputs 0 and `busy`=0 immediately, no write after release.
- ALU only: `alu_valid`, reg 5, data 0xDEADBEEF in cycle N -> cycle N+1 `write_back_en`=1, reg 5, 0xDEADBEEF; cycle N+2 `write_back_en`=0.
- Contention: ALU, MEM, MDU all valid for 4 cycles, then ALU drops -> `mem_ready`=`mdu_ready`=0 for the 4 cycles; afterwards grants alternate MEM, MDU, MEM... starting with MEM.
- Register 0: MEM writes reg 0, data 0x1234 -> `mem_ready`=1, `write_back_en` stays 0, `busy` unchanged.
- Scoreboard: issue reg 7 -> `busy[7]`=1 next cycle; MDU writes reg 7 -> `busy[7]`=0 after commit edge; issue reg 7 in the commit cycle -> `busy[7]` remains 1.
- Back-to-back: MEM valid 3 consecutive cycles alone to regs 1,2,3 -> three consecutive `write_back_en` pulses, regs 1,2,3 in order, `busy` bits cleared one per cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS core's write-back path.
package cpu_pkg;

   localparam int DATA_W   = 32;
   localparam int REG_W    = 5;
   localparam int NUM_REGS = 32;

   // Round-robin pointer encoding for the two back-pressurable producers.
   typedef enum logic {
      SRC_MEM = 1'b0,
      SRC_MDU = 1'b1
   } src_e;

   // Which producer, if any, wins the write port in the current cycle.
   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_ALU  = 2'd1,
      GRANT_MEM  = 2'd2,
      GRANT_MDU  = 2'd3
   } grant_e;

   // One-hot mask selecting register idx in a NUM_REGS-wide vector.
   function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_W-1:0] idx);
      reg_mask      = '0;
      reg_mask[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer/decode-side bundle of the write-back arbiter: three result
// sources, the issue port, the register-file write port and the scoreboard.
interface wb_arbiter_if #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int REG_W  = cpu_pkg::REG_W
);
   import cpu_pkg::*;

   // ALU result (never back-pressured)
   logic              alu_valid;
   logic [REG_W-1:0]  alu_reg;
   logic [DATA_W-1:0] alu_data;

   // Load unit
   logic              mem_valid;
   logic              mem_ready;
   logic [REG_W-1:0]  mem_reg;
   logic [DATA_W-1:0] mem_data;

   // Multiply/divide unit
   logic              mdu_valid;
   logic              mdu_ready;
   logic [REG_W-1:0]  mdu_reg;
   logic [DATA_W-1:0] mdu_data;

   // Decode issue port
   logic              issue_en;
   logic [REG_W-1:0]  issue_reg;

   // Register-file write port and hazard scoreboard
   logic                write_back_en;
   logic [REG_W-1:0]    write_back_reg;
   logic [DATA_W-1:0]   write_back;
   logic [NUM_REGS-1:0] busy;

   // Producers, decode and the register file
   modport master (
      output alu_valid, alu_reg, alu_data,
      output mem_valid, mem_reg, mem_data,
      output mdu_valid, mdu_reg, mdu_data,
      output issue_en, issue_reg,
      input  mem_ready, mdu_ready,
      input  write_back_en, write_back_reg, write_back, busy
   );

   // The arbiter itself
   modport slave (
      input  alu_valid, alu_reg, alu_data,
      input  mem_valid, mem_reg, mem_data,
      input  mdu_valid, mdu_reg, mdu_data,
      input  issue_en, issue_reg,
      output mem_ready, mdu_ready,
      output write_back_en, write_back_reg, write_back, busy
   );

endinterface

// File: rtl/wb_scoreboard.sv
// Register busy scoreboard: a bit is set when decode issues a write to that
// register and cleared when the register file commits it. A set and a clear
// of the same register in one cycle leave the bit set, because the set
// belongs to a newer instruction that is still outstanding. Register 0 is
// hard-wired and never reported busy.
module wb_scoreboard
   import cpu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                set_en,
   input  logic [REG_W-1:0]    set_reg,
   input  logic                clr_en,
   input  logic [REG_W-1:0]    clr_reg,
   output logic [NUM_REGS-1:0] busy
);

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] busy_d;

   // Next busy vector: clear first, then set, so a coincident set wins.
   // NOTE: every signal written here gets a default before any condition,
   // otherwise paths that skip an assignment would infer a latch.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_reg != '0)) begin
         set_mask = reg_mask(set_reg);
      end
      if (clr_en) begin
         clr_mask = reg_mask(clr_reg);
      end
      busy_d    = (busy & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
   end

   // Busy register; reset drops every outstanding write.
   // NOTE: state is updated with non-blocking assignments so every flop
   // samples its inputs at the same edge regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_d;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single-write-port register file. The ALU has
// absolute priority and is never stalled; when it is idle the load unit
// and mul/div unit share the port round-robin. The winning (reg, data) is
// registered and drives the register file one cycle after the handshake.
// Writes to register 0 complete their handshake but are not committed.
module wb_arbiter #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int REG_W  = cpu_pkg::REG_W
) (
   input  logic         clk,
   input  logic         rst,
   wb_arbiter_if.slave  bus
);
   import cpu_pkg::*;

   src_e              rr_ptr;
   grant_e            grant;
   logic              mem_xfer;
   logic              mdu_xfer;
   logic [REG_W-1:0]  win_reg;
   logic [DATA_W-1:0] win_data;

   logic              wb_en_q;
   logic [REG_W-1:0]  wb_reg_q;
   logic [DATA_W-1:0] wb_data_q;

   // Ready handshakes: blocked by any ALU result, and when both MEM and
   // MDU are waiting only the one the round-robin pointer names proceeds.
   assign bus.mem_ready = !bus.alu_valid && (!bus.mdu_valid || (rr_ptr == SRC_MEM));
   assign bus.mdu_ready = !bus.alu_valid && (!bus.mem_valid || (rr_ptr == SRC_MDU));

   assign mem_xfer = bus.mem_valid && bus.mem_ready;
   assign mdu_xfer = bus.mdu_valid && bus.mdu_ready;

   // Resolve the single winner of this cycle and select its payload.
   always_comb begin
      grant    = GRANT_NONE;
      win_reg  = '0;
      win_data = '0;
      if (bus.alu_valid) begin
         grant = GRANT_ALU;
      end else if (mem_xfer) begin
         grant = GRANT_MEM;
      end else if (mdu_xfer) begin
         grant = GRANT_MDU;
      end
      case (grant)
         GRANT_ALU: begin
            win_reg  = bus.alu_reg;
            win_data = bus.alu_data;
         end
         GRANT_MEM: begin
            win_reg  = bus.mem_reg;
            win_data = bus.mem_data;
         end
         GRANT_MDU: begin
            win_reg  = bus.mdu_reg;
            win_data = bus.mdu_data;
         end
         default: begin
            win_reg  = '0;
            win_data = '0;
         end
      endcase
   end

   // Output register and round-robin pointer. The pointer only moves after
   // a MEM or MDU transfer, so ALU bursts do not disturb the fairness order.
   // Reg/data hold their last values whenever nothing is committed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en_q   <= 1'b0;
         wb_reg_q  <= '0;
         wb_data_q <= '0;
         rr_ptr    <= SRC_MEM;
      end else begin
         wb_en_q <= 1'b0;
         if ((grant != GRANT_NONE) && (win_reg != '0)) begin
            wb_en_q   <= 1'b1;
            wb_reg_q  <= win_reg;
            wb_data_q <= win_data;
         end
         if (grant == GRANT_MEM) begin
            rr_ptr <= SRC_MDU;
         end else if (grant == GRANT_MDU) begin
            rr_ptr <= SRC_MEM;
         end
      end
   end

   assign bus.write_back_en  = wb_en_q;
   assign bus.write_back_reg = wb_reg_q;
   assign bus.write_back     = wb_data_q;

   // Busy bits clear at the same edge the register file commits the write.
   wb_scoreboard u_scoreboard (
      .clk     (clk),
      .rst     (rst),
      .set_en  (bus.issue_en),
      .set_reg (bus.issue_reg),
      .clr_en  (wb_en_q),
      .clr_reg (wb_reg_q),
      .busy    (bus.busy)
   );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU latency, priority/round-robin,
// register-0 writes, scoreboard set/clear and back-to-back commits.
module tb_wb_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   wb_arbiter_if bus ();

   wb_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to 1 ns after the next rising edge (inputs change here).
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
      bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
      bus.mdu_valid = 1'b0; bus.mdu_reg = '0; bus.mdu_data = '0;
      bus.issue_en  = 1'b0; bus.issue_reg = '0;
   endtask

   task automatic check_wb(input string tag, input logic en, input logic [4:0] r,
                           input logic [31:0] d);
      check({tag, "_en"},   64'(bus.write_back_en),  64'(en));
      check({tag, "_reg"},  64'(bus.write_back_reg), 64'(r));
      check({tag, "_data"}, 64'(bus.write_back),     64'(d));
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      idle_inputs();
      rst = 1'b1;
      #2;
      // Reset state, ready follows equations during reset
      check_wb("rst0", 1'b0, 5'd0, 32'h0);
      check("rst0_busy", 64'(bus.busy), 64'h0);
      check("rst0_mem_ready", 64'(bus.mem_ready), 64'd1);
      next_cycle();
      next_cycle();
      rst = 1'b0;

      // ALU only: reg 5 <- DEADBEEF
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
      #1;
      check("alu_mem_ready", 64'(bus.mem_ready), 64'd0);
      next_cycle();
      bus.alu_valid = 1'b0;
      check_wb("alu_n1", 1'b1, 5'd5, 32'hDEAD_BEEF);
      next_cycle();
      check_wb("alu_n2", 1'b0, 5'd5, 32'hDEAD_BEEF);

      // Contention: ALU starves MEM/MDU for 4 cycles
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd10; bus.alu_data = 32'hA0A0_A0A0;
      bus.mem_valid = 1'b1; bus.mem_reg = 5'd11; bus.mem_data = 32'h1111_0000;
      bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd12; bus.mdu_data = 32'h2222_0000;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cont_mem_ready", 64'(bus.mem_ready), 64'd0);
         check("cont_mdu_ready", 64'(bus.mdu_ready), 64'd0);
         next_cycle();
         check_wb("cont_alu", 1'b1, 5'd10, 32'hA0A0_A0A0);
      end
      // ALU drops: MEM, MDU, MEM, MDU
      bus.alu_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr_mem_ready", 64'(bus.mem_ready), 64'((i % 2) == 0));
         check("rr_mdu_ready", 64'(bus.mdu_ready), 64'((i % 2) == 1));
         next_cycle();
         if ((i % 2) == 0) check_wb("rr_mem", 1'b1, 5'd11, 32'h1111_0000);
         else              check_wb("rr_mdu", 1'b1, 5'd12, 32'h2222_0000);
      end
      bus.mem_valid = 1'b0;
      bus.mdu_valid = 1'b0;
      next_cycle();
      check_wb("cont_idle", 1'b0, 5'd12, 32'h2222_0000);

      // Register 0: handshake completes, no commit, no busy change
      bus.mem_valid = 1'b1; bus.mem_reg = 5'd0; bus.mem_data = 32'h0000_1234;
      bus.issue_en  = 1'b1; bus.issue_reg = 5'd0;
      #1;
      check("r0_mem_ready", 64'(bus.mem_ready), 64'd1);
      next_cycle();
      bus.mem_valid = 1'b0;
      bus.issue_en  = 1'b0;
      check_wb("r0_n1", 1'b0, 5'd12, 32'h2222_0000);
      check("r0_busy", 64'(bus.busy), 64'h0);
      next_cycle();
      check_wb("r0_n2", 1'b0, 5'd12, 32'h2222_0000);

      // Scoreboard: issue r7, MDU writes r7 and clears it
      bus.issue_en = 1'b1; bus.issue_reg = 5'd7;
      next_cycle();
      bus.issue_en = 1'b0;
      check("sb_set7", 64'(bus.busy), 64'h80);
      bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd7; bus.mdu_data = 32'h0000_0077;
      #1;
      check("sb_mdu_ready", 64'(bus.mdu_ready), 64'd1);
      next_cycle();
      bus.mdu_valid = 1'b0;
      check_wb("sb_commit", 1'b1, 5'd7, 32'h0000_0077);
      check("sb_busy_commit", 64'(bus.busy), 64'h80);
      next_cycle();
      check("sb_cleared", 64'(bus.busy), 64'h0);

      // Re-issue r7 in the commit cycle: set wins
      bus.issue_en = 1'b1; bus.issue_reg = 5'd7;
      next_cycle();
      bus.issue_en = 1'b0;
      bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd7; bus.mdu_data = 32'h0000_0777;
      next_cycle();
      bus.mdu_valid = 1'b0;
      bus.issue_en  = 1'b1; bus.issue_reg = 5'd7;
      check_wb("sb_commit2", 1'b1, 5'd7, 32'h0000_0777);
      next_cycle();
      bus.issue_en = 1'b0;
      check("sb_set_wins", 64'(bus.busy), 64'h80);

      // Back-to-back: issue r1..r3, then MEM writes r1..r3 in a row
      for (int r = 1; r <= 3; r++) begin
         bus.issue_en = 1'b1; bus.issue_reg = 5'(r);
         next_cycle();
      end
      bus.issue_en = 1'b0;
      check("b2b_busy_set", 64'(bus.busy), 64'h8E);
      for (int r = 1; r <= 3; r++) begin
         bus.mem_valid = 1'b1; bus.mem_reg = 5'(r); bus.mem_data = 32'h100 + 32'(r);
         next_cycle();
         check_wb("b2b_wb", 1'b1, 5'(r), 32'h100 + 32'(r));
      end
      check("b2b_busy_r3", 64'(bus.busy), 64'h88);
      bus.mem_valid = 1'b0;
      next_cycle();
      check("b2b_en_off", 64'(bus.write_back_en), 64'd0);
      check("b2b_busy_end", 64'(bus.busy), 64'h80);

      // Reset mid-cycle with a pending write and rr_ptr at MDU
      bus.alu_valid = 1'b1; bus.alu_reg = 5'd9; bus.alu_data = 32'h0000_0099;
      bus.issue_en  = 1'b1; bus.issue_reg = 5'd4;
      next_cycle();
      idle_inputs();
      bus.mem_valid = 1'b1; bus.mdu_valid = 1'b1;
      check("rst_pending_en", 64'(bus.write_back_en), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_wb("rst_mid", 1'b0, 5'd0, 32'h0);
      check("rst_mid_busy", 64'(bus.busy), 64'h0);
      check("rst_mid_mem_ready", 64'(bus.mem_ready), 64'd1);
      check("rst_mid_mdu_ready", 64'(bus.mdu_ready), 64'd0);
      next_cycle();
      idle_inputs();
      rst = 1'b0;
      next_cycle();
      check_wb("rst_after", 1'b0, 5'd0, 32'h0);
      check("rst_after_busy", 64'(bus.busy), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
